// File: rtl/fft_pkg.sv
// Shared types for the FFT peak detector: magnitude width/type and FSM states.
package fft_pkg;

    localparam int unsigned MAG_W = 21;

    typedef logic [MAG_W-1:0] mag_t;

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;

endpackage

// File: rtl/fft_peak_detector_if.sv
// Per-bin magnitude stream from the FFT wrapper (no backpressure).
interface fft_peak_detector_if #(
    parameter int unsigned MAG_W = fft_pkg::MAG_W
);

    logic [MAG_W-1:0] mag_in;
    logic             mag_valid;
    logic             mag_sop;

    modport master (
        output mag_in,
        output mag_valid,
        output mag_sop
    );

    modport slave (
        input mag_in,
        input mag_valid,
        input mag_sop
    );

endinterface

// File: rtl/fft_peak_cmp.sv
// Combinational search-window test plus strict-greater compare; o_update
// says the presented bin becomes the new best candidate.
module fft_peak_cmp #(
    parameter int unsigned FFT_PTS       = 1024,
    parameter int unsigned MAG_W         = 21,
    parameter int unsigned SKIP_BINS     = 1,
    parameter int unsigned HALF_SPECTRUM = 1
) (
    input  logic [$clog2(FFT_PTS)-1:0] i_bin,
    input  logic [MAG_W-1:0]           i_mag,
    input  logic [MAG_W-1:0]           i_best_mag,
    input  logic                       i_have_best,
    output logic                       o_update
);

    localparam int unsigned LAST = (HALF_SPECTRUM != 0) ? (FFT_PTS / 2 - 1) : (FFT_PTS - 1);

    logic w_in_window;

    // Strict compare keeps the lowest index on ties; first in-window bin always seeds.
    always_comb begin
        w_in_window = (32'(i_bin) >= SKIP_BINS) && (32'(i_bin) <= LAST);
        o_update    = w_in_window && (!i_have_best || (i_mag > i_best_mag));
    end

endmodule

// File: rtl/fft_peak_detector.sv
// Per-frame peak search over the FFT magnitude stream.
// Optional macro FFT_PEAK_THRESH_EN adds the thresh input and peak_hit output.
module fft_peak_detector
    import fft_pkg::*;
#(
    parameter int unsigned FFT_PTS       = 1024,
    parameter int unsigned MAG_W         = fft_pkg::MAG_W,
    parameter int unsigned SKIP_BINS     = 1,
    parameter int unsigned HALF_SPECTRUM = 1
) (
    input  logic                       clk,
    input  logic                       reset_n,
    fft_peak_detector_if.slave         mag_if,
`ifdef FFT_PEAK_THRESH_EN
    input  logic [MAG_W-1:0]           thresh,
    output logic                       peak_hit,
`endif
    output logic [$clog2(FFT_PTS)-1:0] peak_bin,
    output logic [MAG_W-1:0]           peak_mag,
    output logic                       peak_valid,
    output logic                       frame_err,
    output logic [15:0]                frame_cnt
);

    localparam int unsigned BW = $clog2(FFT_PTS);
    localparam logic [BW-1:0] LAST_BIN = BW'(FFT_PTS - 1);

    state_t            r_state, w_state_nxt;
    logic [BW-1:0]     r_bin_cnt, w_bin_cnt_nxt;
    logic [MAG_W-1:0]  r_best_mag, w_best_mag_nxt;
    logic [BW-1:0]     r_best_bin, w_best_bin_nxt;
    logic              r_have_best, w_have_best_nxt;

    logic              w_start, w_restart, w_last;
    logic [BW-1:0]     w_cmp_bin, w_cmp_best_bin;
    logic [MAG_W-1:0]  w_cmp_best_mag;
    logic              w_cmp_have_best, w_update;
    logic [BW-1:0]     w_cand_bin;
    logic [MAG_W-1:0]  w_cand_mag;

    logic [BW-1:0]     r_peak_bin;
    logic [MAG_W-1:0]  r_peak_mag;
    logic              r_peak_valid, r_frame_err;
    logic [15:0]       r_frame_cnt;

    // Classify the current sample: frame start, truncating restart, or final bin.
    always_comb begin
        w_start   = 1'b0;
        w_restart = 1'b0;
        w_last    = 1'b0;
        if (mag_if.mag_valid) begin
            case (r_state)
                IDLE: w_start = mag_if.mag_sop;
                ACCUM: begin
                    if (r_bin_cnt == LAST_BIN) begin
                        w_last = 1'b1;
                    end else if (mag_if.mag_sop) begin
                        w_start   = 1'b1;
                        w_restart = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // A starting sample is judged as bin 0 against a cleared best.
    always_comb begin
        w_cmp_bin       = w_start ? '0 : r_bin_cnt;
        w_cmp_best_bin  = w_start ? '0 : r_best_bin;
        w_cmp_best_mag  = w_start ? '0 : r_best_mag;
        w_cmp_have_best = w_start ? 1'b0 : r_have_best;
    end

    fft_peak_cmp #(
        .FFT_PTS       (FFT_PTS),
        .MAG_W         (MAG_W),
        .SKIP_BINS     (SKIP_BINS),
        .HALF_SPECTRUM (HALF_SPECTRUM)
    ) u_cmp (
        .i_bin       (w_cmp_bin),
        .i_mag       (mag_if.mag_in),
        .i_best_mag  (w_cmp_best_mag),
        .i_have_best (w_cmp_have_best),
        .o_update    (w_update)
    );

    // Next-state and best-candidate update; the final bin is folded into the report.
    always_comb begin
        w_cand_mag      = w_update ? mag_if.mag_in : w_cmp_best_mag;
        w_cand_bin      = w_update ? w_cmp_bin : w_cmp_best_bin;
        w_state_nxt     = r_state;
        w_bin_cnt_nxt   = r_bin_cnt;
        w_best_mag_nxt  = r_best_mag;
        w_best_bin_nxt  = r_best_bin;
        w_have_best_nxt = r_have_best;
        if (w_start) begin
            w_state_nxt     = ACCUM;
            w_bin_cnt_nxt   = BW'(1);
            w_best_mag_nxt  = w_cand_mag;
            w_best_bin_nxt  = w_cand_bin;
            w_have_best_nxt = w_update;
        end else if (w_last) begin
            w_state_nxt     = IDLE;
            w_bin_cnt_nxt   = '0;
            w_best_mag_nxt  = '0;
            w_best_bin_nxt  = '0;
            w_have_best_nxt = 1'b0;
        end else if ((r_state == ACCUM) && mag_if.mag_valid) begin
            w_bin_cnt_nxt   = r_bin_cnt + BW'(1);
            w_best_mag_nxt  = w_cand_mag;
            w_best_bin_nxt  = w_cand_bin;
            w_have_best_nxt = r_have_best | w_update;
        end
    end

    // FSM state and running search registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_bin_cnt   <= '0;
            r_best_mag  <= '0;
            r_best_bin  <= '0;
            r_have_best <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_bin_cnt   <= w_bin_cnt_nxt;
            r_best_mag  <= w_best_mag_nxt;
            r_best_bin  <= w_best_bin_nxt;
            r_have_best <= w_have_best_nxt;
        end
    end

    // Registered report, error pulse and frame counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_peak_bin   <= '0;
            r_peak_mag   <= '0;
            r_peak_valid <= 1'b0;
            r_frame_err  <= 1'b0;
            r_frame_cnt  <= '0;
        end else begin
            r_peak_valid <= w_last;
            r_frame_err  <= w_restart;
            if (w_last) begin
                r_peak_bin  <= w_cand_bin;
                r_peak_mag  <= w_cand_mag;
                r_frame_cnt <= r_frame_cnt + 16'd1;
            end
        end
    end

`ifdef FFT_PEAK_THRESH_EN
    logic r_peak_hit;

    // Threshold flag is compared against thresh as sampled on the last-bin cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_peak_hit <= 1'b0;
        end else if (w_last) begin
            r_peak_hit <= (w_cand_mag >= thresh);
        end
    end

    assign peak_hit = r_peak_hit;
`endif

    assign peak_bin   = r_peak_bin;
    assign peak_mag   = r_peak_mag;
    assign peak_valid = r_peak_valid;
    assign frame_err  = r_frame_err;
    assign frame_cnt  = r_frame_cnt;

endmodule

// File: tb/tb_fft_peak_detector.sv
// Directed bench for fft_peak_detector with FFT_PTS=16, SKIP_BINS=1, HALF_SPECTRUM=1.
module tb_fft_peak_detector;
    import fft_pkg::*;

    localparam int unsigned PTS = 16;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [3:0]  peak_bin;
    mag_t        peak_mag;
    logic        peak_valid;
    logic        frame_err;
    logic [15:0] frame_cnt;
`ifdef FFT_PEAK_THRESH_EN
    mag_t        thresh;
    logic        peak_hit;
`endif

    int n_checks = 0;
    int n_errors = 0;
    int pv_seen  = 0;
    int err_seen = 0;

    mag_t f_ramp [PTS];
    mag_t f_tie  [PTS];
    mag_t f_mid  [PTS];
    mag_t f_mir  [PTS];

    fft_peak_detector_if #(.MAG_W(MAG_W)) mag_if ();

    fft_peak_detector #(
        .FFT_PTS       (PTS),
        .MAG_W         (MAG_W),
        .SKIP_BINS     (1),
        .HALF_SPECTRUM (1)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .mag_if     (mag_if),
`ifdef FFT_PEAK_THRESH_EN
        .thresh     (thresh),
        .peak_hit   (peak_hit),
`endif
        .peak_bin   (peak_bin),
        .peak_mag   (peak_mag),
        .peak_valid (peak_valid),
        .frame_err  (frame_err),
        .frame_cnt  (frame_cnt)
    );

    always #5 clk = ~clk;

    // Count output pulses shortly after each edge.
    always @(posedge clk) begin
        #1;
        if (peak_valid) pv_seen++;
        if (frame_err) err_seen++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic put(input mag_t m, input logic v, input logic s);
        @(negedge clk);
        mag_if.mag_in    = m;
        mag_if.mag_valid = v;
        mag_if.mag_sop   = s;
    endtask

    // Returns at the negedge where the report for the last bin is visible.
    task automatic send_frame(input mag_t f [PTS], input bit gap);
        for (int i = 0; i < PTS; i++) begin
            if (gap && i > 0) put(21'h1FFFFF, 1'b0, 1'b1);
            put(f[i], 1'b1, (i == 0));
        end
        put('0, 1'b0, 1'b0);
    endtask

    task automatic check_report(input string tag, input int b, input int m, input int cnt);
        check({tag, "_pv"}, 32'(peak_valid), 1);
        check({tag, "_bin"}, 32'(peak_bin), b);
        check({tag, "_mag"}, 32'(peak_mag), m);
        check({tag, "_cnt"}, 32'(frame_cnt), cnt);
        put('0, 1'b0, 1'b0);
        check({tag, "_pv_low"}, 32'(peak_valid), 0);
        check({tag, "_bin_hold"}, 32'(peak_bin), b);
    endtask

    initial begin
        for (int i = 0; i < PTS; i++) begin
            f_ramp[i] = mag_t'(i * 10);
            f_tie[i]  = mag_t'(10);
            f_mid[i]  = mag_t'(20);
            f_mir[i]  = (i >= 8) ? mag_t'(900) : '0;
        end
        f_ramp[0] = mag_t'(999);
        f_tie[3]  = mag_t'(500);
        f_tie[5]  = mag_t'(500);
        f_mid[4]  = mag_t'(300);
        f_mir[0]  = mag_t'(999);

        reset_n          = 1'b0;
        mag_if.mag_in    = '0;
        mag_if.mag_valid = 1'b0;
        mag_if.mag_sop   = 1'b0;
`ifdef FFT_PEAK_THRESH_EN
        thresh           = '0;
`endif
        repeat (3) @(negedge clk);
        check("rst_bin", 32'(peak_bin), 0);
        check("rst_mag", 32'(peak_mag), 0);
        check("rst_pv", 32'(peak_valid), 0);
        check("rst_err", 32'(frame_err), 0);
        check("rst_cnt", 32'(frame_cnt), 0);
`ifdef FFT_PEAK_THRESH_EN
        check("rst_hit", 32'(peak_hit), 0);
`endif
        reset_n = 1'b1;

        // Valid non-SOP samples while idle are dropped.
        put(mag_t'(5000), 1'b1, 1'b0);
        put(mag_t'(5000), 1'b1, 1'b0);

        // Ramp with large DC bin: DC and upper half ignored.
        send_frame(f_ramp, 1'b0);
        check("t1_pv_count", 32'(pv_seen), 1);
        check_report("t1", 7, 70, 1);

        // Tie between bins 3 and 5 resolves to the lower index.
        send_frame(f_tie, 1'b0);
        check_report("t2", 3, 500, 2);

        // Gaps with mag_valid low (garbage data, sop high) hold state.
        send_frame(f_ramp, 1'b1);
        check_report("t3", 7, 70, 3);
        check("t3_pv_count", 32'(pv_seen), 3);

        // SOP at bin 9 truncates the frame and restarts.
        for (int i = 0; i < 9; i++) put(f_ramp[i], 1'b1, (i == 0));
        for (int i = 0; i < PTS; i++) begin
            put(f_mid[i], 1'b1, (i == 0));
            if (i == 1) begin
                check("t4_err", 32'(frame_err), 1);
                check("t4_err_pv", 32'(peak_valid), 0);
                check("t4_bin_held", 32'(peak_bin), 7);
            end
            if (i == 2) check("t4_err_low", 32'(frame_err), 0);
        end
        put('0, 1'b0, 1'b0);
        check("t4_err_count", 32'(err_seen), 1);
        check("t4_pv_count", 32'(pv_seen), 4);
        check_report("t4", 4, 300, 4);

        // Back-to-back frames with no idle cycle between them.
        for (int i = 0; i < 2 * PTS; i++) begin
            if (i < PTS) put(f_ramp[i], 1'b1, (i == 0));
            else         put(f_tie[i - PTS], 1'b1, (i == PTS));
            if (i == PTS) begin
                check("t5a_pv", 32'(peak_valid), 1);
                check("t5a_bin", 32'(peak_bin), 7);
                check("t5a_mag", 32'(peak_mag), 70);
                check("t5a_cnt", 32'(frame_cnt), 5);
            end
            if (i == PTS + 1) check("t5a_pv_low", 32'(peak_valid), 0);
        end
        put('0, 1'b0, 1'b0);
        check("t5_pv_count", 32'(pv_seen), 6);
        check_report("t5b", 3, 500, 6);

        // In-window bins all zero, mirrored half large: first window bin wins.
        send_frame(f_mir, 1'b0);
        check_report("t_mir", 1, 0, 7);

        // Reset in the middle of a frame aborts it silently.
        for (int i = 0; i < 6; i++) put(f_ramp[i], 1'b1, (i == 0));
        @(negedge clk);
        reset_n          = 1'b0;
        mag_if.mag_valid = 1'b0;
        @(negedge clk);
        check("t6_rst_bin", 32'(peak_bin), 0);
        check("t6_rst_mag", 32'(peak_mag), 0);
        check("t6_rst_cnt", 32'(frame_cnt), 0);
        reset_n = 1'b1;
        // Remaining bins of the aborted frame arrive with no SOP and are dropped.
        for (int i = 6; i < PTS; i++) put(f_ramp[i], 1'b1, 1'b0);
        put('0, 1'b0, 1'b0);
        check("t6_no_report", 32'(pv_seen), 7);
        check("t6_bin_zero", 32'(peak_bin), 0);
`ifdef FFT_PEAK_THRESH_EN
        thresh = mag_t'(70);
`endif
        send_frame(f_ramp, 1'b0);
`ifdef FFT_PEAK_THRESH_EN
        check("t6_hit70", 32'(peak_hit), 1);
        thresh = mag_t'(71);
`endif
        check_report("t6", 7, 70, 1);
        check("t6_err_count", 32'(err_seen), 1);
        send_frame(f_ramp, 1'b0);
`ifdef FFT_PEAK_THRESH_EN
        check("t6_hit71", 32'(peak_hit), 0);
`endif
        check_report("t7", 7, 70, 2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
